// File: rtl/seg_scan_if.sv
// seg_scan_if: bundle between the 7-segment scanner, the game/score logic
// that loads it, the hex-to-segment decoder it drives, and the board pins.
//   load/value/dp_in       : tear-free display value update (host -> scanner)
//   en_mask/lz_blank       : live per-digit enable and leading-zero blanking
//   nibble/seg_in          : digit code out to decoder, active-low pattern back
//   seg/dp/an              : active-low pin drive
//   frame_done             : one-cycle pulse at the end of the last digit slot
// master = the scanner, slave = everything around it.
interface seg_scan_if #(
  parameter int NUM_DIGITS = 8
);
  logic                       load;
  logic [NUM_DIGITS-1:0][3:0] value;
  logic [NUM_DIGITS-1:0]      dp_in;
  logic [NUM_DIGITS-1:0]      en_mask;
  logic                       lz_blank;
  logic [3:0]                 nibble;
  logic [6:0]                 seg_in;
  logic [6:0]                 seg;
  logic                       dp;
  logic [NUM_DIGITS-1:0]      an;
  logic                       frame_done;

  modport master (
    input  load, value, dp_in, en_mask, lz_blank, seg_in,
    output nibble, seg, dp, an, frame_done
  );

  modport slave (
    output load, value, dp_in, en_mask, lz_blank, seg_in,
    input  nibble, seg, dp, an, frame_done
  );
endinterface

// File: rtl/seg_scan.sv
// seg_scan: multiplexed driver for a common-anode 7-segment bank.
// Scans one digit per CLK_DIV-cycle slot; the first BLANK_CYC cycles of each
// slot keep every anode off so the previous digit's pattern cannot ghost.
// A loaded value waits in a shadow register and becomes visible only at the
// frame wrap, so a frame never mixes digits from two different values.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : seg_scan_if.master (load/value/dp_in/en_mask/lz_blank in,
//                nibble/seg/dp/an/frame_done out, seg_in from decoder)

// One digit of the leading-zero chain: high when this digit and every digit
// above it are zero.
module seg_scan_lane (
  input  logic [3:0] digit,
  input  logic       zeroIn,
  output logic       zeroOut
);
  assign zeroOut = zeroIn && (digit == 4'h0);
endmodule

module seg_scan #(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_DIV    = 100000,
  parameter int BLANK_CYC  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  seg_scan_if.master bus
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [DW-1:0]              div, divNext;
  logic [IW-1:0]              idx, idxNext;
  logic [NUM_DIGITS-1:0][3:0] activeVal, activeValNext, shadowVal;
  logic [NUM_DIGITS-1:0]      activeDp, activeDpNext, shadowDp;
  logic                       pending;
  logic [3:0]                 nibble;
  logic [NUM_DIGITS-1:0]      an, anNext;
  logic                       frameDone;
  logic                       slotEnd, wrap, lit;
  logic [NUM_DIGITS:0]        zeroFrom;

  // Leading-zero chain runs on the value the next slot will display, so the
  // registered anode matches the digit shown after a frame wrap.
  assign zeroFrom[NUM_DIGITS] = 1'b1;
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : gLane
    seg_scan_lane uLane (
      .digit   (activeValNext[g]),
      .zeroIn  (zeroFrom[g+1]),
      .zeroOut (zeroFrom[g])
    );
  end

  always_comb begin
    slotEnd = (div == DIV_LAST);
    wrap    = slotEnd && (idx == IDX_LAST);
    divNext = slotEnd ? '0 : div + DW'(1);
    idxNext = idx;
    if (wrap)         idxNext = '0;
    else if (slotEnd) idxNext = idx + IW'(1);

    // A load on the wrap edge bypasses the shadow and lands in this frame.
    activeValNext = activeVal;
    activeDpNext  = activeDp;
    if (wrap) begin
      if (bus.load) begin
        activeValNext = bus.value;
        activeDpNext  = bus.dp_in;
      end else if (pending) begin
        activeValNext = shadowVal;
        activeDpNext  = shadowDp;
      end
    end

    // Digit 0 is never leading-zero blanked, so "0" stays visible.
    lit = bus.en_mask[idxNext] &&
          !(bus.lz_blank && (idxNext != '0) && zeroFrom[idxNext]);

    anNext = '1;
    if (int'(divNext) >= BLANK_CYC) anNext[idxNext] = ~lit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div       <= '0;
      idx       <= '0;
      activeVal <= '0;
      activeDp  <= '0;
      shadowVal <= '0;
      shadowDp  <= '0;
      pending   <= 1'b0;
      nibble    <= 4'h0;
      an        <= '1;
      frameDone <= 1'b0;
    end else begin
      div       <= divNext;
      idx       <= idxNext;
      activeVal <= activeValNext;
      activeDp  <= activeDpNext;
      an        <= anNext;
      frameDone <= wrap;
      if (slotEnd) nibble <= activeValNext[idxNext];
      if (bus.load) begin
        shadowVal <= bus.value;
        shadowDp  <= bus.dp_in;
      end
      if (wrap)          pending <= 1'b0;
      else if (bus.load) pending <= 1'b1;
    end
  end

  // seg is a straight combinational path from the decoder; both seg and dp
  // are forced dark whenever no anode is selected.
  assign bus.nibble     = nibble;
  assign bus.an         = an;
  assign bus.frame_done = frameDone;
  assign bus.seg        = (&an) ? 7'h7F : bus.seg_in;
  assign bus.dp         = (&an) ? 1'b1 : ~activeDp[idx];
endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan with NUM_DIGITS=4, CLK_DIV=4, BLANK_CYC=1 and a
// behavioural decoder on the nibble/seg_in loop. Expected outputs come from
// elapsed-cycle arithmetic (slot = t / CLK_DIV, frame = t / (N*CLK_DIV)) and a
// per-frame record of the displayed value.
module tb_seg_scan;
  localparam int N     = 4;
  localparam int CD    = 4;
  localparam int BC    = 1;
  localparam int FRAME = N * CD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_if #(.NUM_DIGITS(N)) bus ();

  seg_scan #(.NUM_DIGITS(N), .CLK_DIV(CD), .BLANK_CYC(BC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  always_comb bus.seg_in = hex7(bus.nibble);

  int total = 0;
  int bad   = 0;

  // reference state: cycles since reset release, displayed value, pending load
  int          c = 0;
  logic [15:0] actV = '0, shV = '0;
  logic [3:0]  actD = '0, shD = '0;
  bit          pend = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s c=%0d observed=%h expected=%h", tag, c, obs, exp);
    end
  endtask

  function automatic bit litM(input int i);
    bit zeroAbove = 1'b1;
    for (int j = i; j < N; j++)
      if (((actV >> (4 * j)) & 16'hF) != 0) zeroAbove = 1'b0;
    return bus.en_mask[i] && !(bus.lz_blank && i != 0 && zeroAbove);
  endfunction

  task automatic checkAll();
    int d = c % CD;
    int i = (c / CD) % N;
    logic [3:0] expAn  = 4'hF;
    logic [3:0] expNib = 4'((actV >> (4 * i)) & 16'hF);
    logic [6:0] expSeg;
    logic       expDp;
    if (d >= BC && litM(i)) expAn[i] = 1'b0;
    expSeg = (expAn == 4'hF) ? 7'h7F : hex7(expNib);
    expDp  = (expAn == 4'hF) ? 1'b1 : ~actD[i];
    chk("an",         32'(bus.an),         32'(expAn));
    chk("nibble",     32'(bus.nibble),     32'(expNib));
    chk("seg",        32'(bus.seg),        32'(expSeg));
    chk("dp",         32'(bus.dp),         32'(expDp));
    chk("frame_done", 32'(bus.frame_done), 32'(c > 0 && c % FRAME == 0));
  endtask

  // One clock: update the reference at the edge, then check at the falling edge.
  task automatic step();
    @(posedge clk);
    c++;
    if (c % FRAME == 0) begin
      if (bus.load) begin
        actV = bus.value;
        actD = bus.dp_in;
      end else if (pend) begin
        actV = shV;
        actD = shD;
      end
      pend = 1'b0;
    end else if (bus.load) begin
      shV  = bus.value;
      shD  = bus.dp_in;
      pend = 1'b1;
    end
    @(negedge clk);
    bus.load = 1'b0;
    checkAll();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic toPhase(input int ph);
    while (c % FRAME != ph) step();
  endtask

  task automatic doLoad(input logic [15:0] v, input logic [3:0] d);
    bus.value = v;
    bus.dp_in = d;
    bus.load  = 1'b1;
    step();
  endtask

  // live controls change only during a blanked cycle so the registered anode
  // and the reference agree on which inputs were seen
  task automatic setLive(input logic [3:0] en, input logic lz);
    while (c % CD != 0) step();
    bus.en_mask  = en;
    bus.lz_blank = lz;
  endtask

  initial begin
    bus.load     = 1'b0;
    bus.value    = '0;
    bus.dp_in    = '0;
    bus.en_mask  = 4'hF;
    bus.lz_blank = 1'b0;

    // 1: reset state, then two plain frames of zero
    repeat (2) @(negedge clk);
    chk("rst_an",  32'(bus.an),  32'hF);
    chk("rst_seg", 32'(bus.seg), 32'h7F);
    chk("rst_dp",  32'(bus.dp),  32'h1);
    chk("rst_fd",  32'(bus.frame_done), 32'h0);
    rst_n = 1'b1;
    checkAll();
    run(2 * FRAME);

    // 2: mid-frame load shows from the next frame
    toPhase(6);
    doLoad(16'h1234, 4'h0);
    run(2 * FRAME);

    // 3: leading-zero blanking
    setLive(4'hF, 1'b1);
    doLoad(16'h0050, 4'h0);
    run(2 * FRAME);
    doLoad(16'h0000, 4'hF);
    run(2 * FRAME);

    // 4: last of several loads wins; load on the wrap edge lands immediately
    setLive(4'hF, 1'b0);
    toPhase(2);
    doLoad(16'hAAAA, 4'h1);
    run(2);
    doLoad(16'hBBBB, 4'h2);
    toPhase(10);
    doLoad(16'h00C1, 4'h4);
    run(FRAME);
    toPhase(15);
    doLoad(16'h9876, 4'h8);
    run(FRAME);

    // 5: per-digit enable with decimal points
    setLive(4'b1010, 1'b0);
    doLoad(16'h1234, 4'b0011);
    run(2 * FRAME);

    // randomized loads and live-control changes
    repeat (25) begin
      run($urandom_range(0, 20));
      if ($urandom_range(0, 3) == 0)
        setLive(4'($urandom), 1'($urandom));
      doLoad($urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 255)),
             4'($urandom));
    end
    run(2 * FRAME);

    // 6: async reset mid-slot at idx 2 drops the pending load
    setLive(4'hF, 1'b0);
    toPhase(7);
    doLoad(16'h5555, 4'hF);
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_an",     32'(bus.an),         32'hF);
    chk("midrst_dp",     32'(bus.dp),         32'h1);
    chk("midrst_seg",    32'(bus.seg),        32'h7F);
    chk("midrst_nibble", 32'(bus.nibble),     32'h0);
    chk("midrst_fd",     32'(bus.frame_done), 32'h0);
    c    = 0;
    actV = '0;
    actD = '0;
    pend = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkAll();
    run(2 * FRAME + 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
